// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the memory port arbiter:
//   WORD_W       - width of memory words and addresses (16)
//   FETCH_BEATS  - beats in one instruction fetch burst (opcode + argument)
//   arb_state_e  - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int WORD_W      = 16;
    localparam int FETCH_BEATS = 2;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,   // no grant
        ARB_F_OPC   = 3'd1,   // fetch beat 1 (opcode)
        ARB_F_ARG   = 3'd2,   // fetch beat 2 (argument)
        ARB_D_ACC   = 3'd3,   // single data beat
        ARB_F_DRAIN = 3'd4    // flushed fetch beat still owed by memory
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch, data and memory-side signals of the arbiter.
//   master modport : the arbiter itself (drives done/result/memory signals)
//   slave modport  : the surrounding system (fetch unit, load/store, memory)
// Fetch side : f_req, f_addr, f_flush -> f_done, f_opc, f_arg, hold
// Data side  : d_req, d_we, d_addr, d_wdata -> d_done, d_rdata
// Memory side: mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
// Debug      : state (current arbiter FSM state)
//
// Handshake: a requester raises *_req and holds it, with stable qualifiers,
// until it sees its *_done pulse; it must drop *_req in that same done cycle,
// since the arbiter may grant again from IDLE at the end of it. On the memory
// side a beat is presented while mem_req=1 and completes in the cycle
// mem_ready=1; address/data stay stable until then.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    import core_pkg::*;

    logic              f_req;
    logic [WORD_W-1:0] f_addr;
    logic              f_flush;
    logic              f_done;
    logic [WORD_W-1:0] f_opc;
    logic [WORD_W-1:0] f_arg;
    logic              hold;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_done;
    logic [WORD_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;

    arb_state_e        state;

    modport master (
        input  f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata,
               mem_rdata, mem_ready,
        output f_done, f_opc, f_arg, hold, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, state
    );

    modport slave (
        output f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata,
               mem_rdata, mem_ready,
        input  f_done, f_opc, f_arg, hold, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, state
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one 16-bit memory port between the instruction fetch unit (two-beat
// burst: opcode at addr, argument at addr+1) and the data load/store path
// (single read or write beat). Data has priority over fetch. The fetch result
// is delivered as opcode+argument together with a one-cycle f_done; hold stalls
// the fetch unit/decoder in every other cycle. All outputs are registered.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.master (fetch, data, memory and debug state)
//
// Optional feature (macro ARB_FAIRNESS_EN): a saturating counter of data grants
// made while a fetch waits; once it reaches STARVE_LIMIT the next grant from
// IDLE goes to the fetch. Without the macro, data priority is strict and
// neither the counter nor STARVE_LIMIT exists.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import core_pkg::*;
`ifdef ARB_FAIRNESS_EN
    #(parameter int STARVE_LIMIT = 4)
`endif
(
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    // Distance from the opcode word to the argument word of a burst.
    localparam logic [WORD_W-1:0] ARG_OFFSET = WORD_W'(FETCH_BEATS - 1);

    arb_state_e        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [WORD_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic [WORD_W-1:0] r_opc_buf;
    logic [WORD_W-1:0] r_f_opc;
    logic [WORD_W-1:0] r_f_arg;
    logic [WORD_W-1:0] r_d_rdata;
    logic              r_f_done;
    logic              r_d_done;
    logic              r_hold;

    logic              w_f_pending;
    logic              w_fetch_first;
    logic              w_grant_d;
    logic              w_grant_f;

    // A fetch asked for together with a flush is dropped, not granted.
    assign w_f_pending = bus.f_req & ~bus.f_flush;

`ifdef ARB_FAIRNESS_EN
    logic [2:0] r_starve;

    assign w_fetch_first = (r_starve >= 3'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 3'd0;
        end else if (r_state == ARB_IDLE) begin
            if (w_grant_f) begin
                r_starve <= 3'd0;
            end else if (w_grant_d && w_f_pending && (r_starve != 3'd7)) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end
`else
    assign w_fetch_first = 1'b0;
`endif

    assign w_grant_d = bus.d_req & ~(w_fetch_first & w_f_pending);
    assign w_grant_f = w_f_pending & ~w_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_opc_buf   <= '0;
            r_f_opc     <= '0;
            r_f_arg     <= '0;
            r_d_rdata   <= '0;
            r_f_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_hold      <= 1'b1;
        end else begin
            // Done pulses last one cycle; hold drops only alongside f_done.
            r_f_done <= 1'b0;
            r_d_done <= 1'b0;
            r_hold   <= 1'b1;

            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ARB_D_ACC;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                    end else if (w_grant_f) begin
                        r_state    <= ARB_F_OPC;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= bus.f_addr;
                    end
                end

                ARB_F_OPC: begin
                    if (bus.mem_ready) begin
                        if (bus.f_flush) begin
                            // Beat finished in the flush cycle: nothing owed.
                            r_state   <= ARB_IDLE;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_opc_buf  <= bus.mem_rdata;
                            r_mem_addr <= r_mem_addr + ARG_OFFSET;
                            r_state    <= ARB_F_ARG;
                        end
                    end else if (bus.f_flush) begin
                        r_state <= ARB_F_DRAIN;
                    end
                end

                ARB_F_ARG: begin
                    if (bus.mem_ready) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                        if (!bus.f_flush) begin
                            r_f_opc  <= r_opc_buf;
                            r_f_arg  <= bus.mem_rdata;
                            r_f_done <= 1'b1;
                            r_hold   <= 1'b0;
                        end
                    end else if (bus.f_flush) begin
                        r_state <= ARB_F_DRAIN;
                    end
                end

                ARB_D_ACC: begin
                    if (bus.mem_ready) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_d_done  <= 1'b1;
                        if (!r_mem_we) begin
                            r_d_rdata <= bus.mem_rdata;
                        end
                    end
                end

                ARB_F_DRAIN: begin
                    // The memory still completes the abandoned beat; its data is dropped.
                    if (bus.mem_ready) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= ARB_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state     = r_state;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.f_done    = r_f_done;
    assign bus.f_opc     = r_f_opc;
    assign bus.f_arg     = r_f_arg;
    assign bus.hold      = r_hold;
    assign bus.d_done    = r_d_done;
    assign bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: reset values, fetch burst, address
// wrap, data-before-fetch priority, write with wait states, flush handling,
// asynchronous reset mid-burst and (with ARB_FAIRNESS_EN) fetch anti-starvation.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import core_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [WORD_W-1:0] mem [0:65535];

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: read data follows the presented address.
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Clock block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        mem[16'h1000] = 16'hA955;
        mem[16'h1001] = 16'h1234;
        mem[16'hFFFF] = 16'h5A5A;
        mem[16'h0000] = 16'hC3C3;
        mem[16'h2000] = 16'hBEEF;
        mem[16'h5000] = 16'h1111;
        mem[16'h5001] = 16'h2222;
        mem[16'h4000] = 16'h7777;
        mem[16'h4001] = 16'h8888;

        rst_n         = 1'b0;
        bus.f_req     = 1'b0;
        bus.f_addr    = '0;
        bus.f_flush   = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        chk("rst_state",   16'(bus.state), 16'(ARB_IDLE));
        chk("rst_mem_req", 16'(bus.mem_req), 16'd0);
        chk("rst_mem_we",  16'(bus.mem_we), 16'd0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        chk("rst_f_done",  16'(bus.f_done), 16'd0);
        chk("rst_d_done",  16'(bus.d_done), 16'd0);
        chk("rst_f_opc",   bus.f_opc, 16'h0000);
        chk("rst_f_arg",   bus.f_arg, 16'h0000);
        chk("rst_d_rdata", bus.d_rdata, 16'h0000);
        chk("rst_hold",    16'(bus.hold), 16'd1);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", 16'(bus.hold), 16'd1);

        // ---------------- fetch, mem_ready always high ----------------
        bus.mem_ready = 1'b1;
        bus.f_req     = 1'b1;
        bus.f_addr    = 16'h1000;
        tick();
        chk("f1_state_opc", 16'(bus.state), 16'(ARB_F_OPC));
        chk("f1_mem_req",   16'(bus.mem_req), 16'd1);
        chk("f1_addr0",     bus.mem_addr, 16'h1000);
        chk("f1_hold_c1",   16'(bus.hold), 16'd1);
        tick();
        chk("f1_state_arg", 16'(bus.state), 16'(ARB_F_ARG));
        chk("f1_addr1",     bus.mem_addr, 16'h1001);
        chk("f1_done_c2",   16'(bus.f_done), 16'd0);
        chk("f1_hold_c2",   16'(bus.hold), 16'd1);
        tick();
        chk("f1_done",      16'(bus.f_done), 16'd1);
        chk("f1_opc",       bus.f_opc, 16'hA955);
        chk("f1_arg",       bus.f_arg, 16'h1234);
        chk("f1_hold_done", 16'(bus.hold), 16'd0);
        chk("f1_req_drop",  16'(bus.mem_req), 16'd0);
        chk("f1_state_idle", 16'(bus.state), 16'(ARB_IDLE));
        bus.f_req = 1'b0;
        tick();
        chk("f1_done_pulse", 16'(bus.f_done), 16'd0);
        chk("f1_hold_after", 16'(bus.hold), 16'd1);

        // ---------------- address wrap ----------------
        bus.f_req  = 1'b1;
        bus.f_addr = 16'hFFFF;
        tick();
        chk("wrap_addr0", bus.mem_addr, 16'hFFFF);
        tick();
        chk("wrap_addr1", bus.mem_addr, 16'h0000);
        tick();
        chk("wrap_done", 16'(bus.f_done), 16'd1);
        chk("wrap_opc",  bus.f_opc, 16'h5A5A);
        chk("wrap_arg",  bus.f_arg, 16'hC3C3);
        bus.f_req = 1'b0;
        tick();

        // ---------------- simultaneous fetch and data read ----------------
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h1000;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h2000;
        tick();
        chk("sim_state_d", 16'(bus.state), 16'(ARB_D_ACC));
        chk("sim_daddr",   bus.mem_addr, 16'h2000);
        chk("sim_we",      16'(bus.mem_we), 16'd0);
        chk("sim_hold1",   16'(bus.hold), 16'd1);
        tick();
        chk("sim_d_done",  16'(bus.d_done), 16'd1);
        chk("sim_rdata",   bus.d_rdata, 16'hBEEF);
        chk("sim_hold2",   16'(bus.hold), 16'd1);
        chk("sim_f_wait",  16'(bus.f_done), 16'd0);
        bus.d_req = 1'b0;
        tick();
        chk("sim_state_f", 16'(bus.state), 16'(ARB_F_OPC));
        chk("sim_faddr",   bus.mem_addr, 16'h1000);
        chk("sim_hold3",   16'(bus.hold), 16'd1);
        tick();
        chk("sim_hold4",   16'(bus.hold), 16'd1);
        tick();
        chk("sim_f_done",  16'(bus.f_done), 16'd1);
        chk("sim_opc",     bus.f_opc, 16'hA955);
        chk("sim_arg",     bus.f_arg, 16'h1234);
        chk("sim_hold5",   16'(bus.hold), 16'd0);
        bus.f_req = 1'b0;
        tick();

        // ---------------- write with two wait cycles ----------------
        bus.mem_ready = 1'b0;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 16'h3000;
        bus.d_wdata   = 16'h00FF;
        tick();
        chk("wr_we_c1",    16'(bus.mem_we), 16'd1);
        chk("wr_addr_c1",  bus.mem_addr, 16'h3000);
        chk("wr_wdata_c1", bus.mem_wdata, 16'h00FF);
        tick();
        chk("wr_we_c2",    16'(bus.mem_we), 16'd1);
        chk("wr_addr_c2",  bus.mem_addr, 16'h3000);
        chk("wr_wdata_c2", bus.mem_wdata, 16'h00FF);
        chk("wr_nodone_c2", 16'(bus.d_done), 16'd0);
        tick();
        chk("wr_req_c3",   16'(bus.mem_req), 16'd1);
        chk("wr_wdata_c3", bus.mem_wdata, 16'h00FF);
        chk("wr_nodone_c3", 16'(bus.d_done), 16'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk("wr_done",     16'(bus.d_done), 16'd1);
        chk("wr_req_drop", 16'(bus.mem_req), 16'd0);
        chk("wr_we_drop",  16'(bus.mem_we), 16'd0);
        chk("wr_rdata_kept", bus.d_rdata, 16'hBEEF);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();

        // ---------------- flush in F_ARG with delayed ready ----------------
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h5000;
        tick();
        tick();
        chk("fl_state_arg", 16'(bus.state), 16'(ARB_F_ARG));
        bus.mem_ready = 1'b0;
        bus.f_flush   = 1'b1;
        tick();
        chk("fl_drain",     16'(bus.state), 16'(ARB_F_DRAIN));
        chk("fl_req_held",  16'(bus.mem_req), 16'd1);
        chk("fl_no_done1",  16'(bus.f_done), 16'd0);
        bus.f_flush = 1'b0;
        bus.f_req   = 1'b0;
        tick();
        chk("fl_drain2",    16'(bus.state), 16'(ARB_F_DRAIN));
        bus.mem_ready = 1'b1;
        tick();
        chk("fl_idle",      16'(bus.state), 16'(ARB_IDLE));
        chk("fl_req_drop",  16'(bus.mem_req), 16'd0);
        chk("fl_no_done2",  16'(bus.f_done), 16'd0);
        chk("fl_opc_kept",  bus.f_opc, 16'hA955);
        chk("fl_hold",      16'(bus.hold), 16'd1);
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h4000;
        tick();
        chk("fl_new_addr0", bus.mem_addr, 16'h4000);
        tick();
        chk("fl_new_addr1", bus.mem_addr, 16'h4001);
        tick();
        chk("fl_new_done",  16'(bus.f_done), 16'd1);
        chk("fl_new_opc",   bus.f_opc, 16'h7777);
        chk("fl_new_arg",   bus.f_arg, 16'h8888);
        bus.f_req = 1'b0;
        tick();

        // ---------------- flush together with mem_ready in F_OPC ----------------
        bus.f_req  = 1'b1;
        bus.f_addr = 16'h6000;
        tick();
        chk("flr_state_opc", 16'(bus.state), 16'(ARB_F_OPC));
        bus.f_flush = 1'b1;
        tick();
        chk("flr_idle",     16'(bus.state), 16'(ARB_IDLE));
        chk("flr_req_drop", 16'(bus.mem_req), 16'd0);
        chk("flr_no_done",  16'(bus.f_done), 16'd0);
        // Flush while the fetch is still only requested: no grant.
        tick();
        chk("fli_idle",     16'(bus.state), 16'(ARB_IDLE));
        chk("fli_no_req",   16'(bus.mem_req), 16'd0);
        bus.f_flush = 1'b0;
        bus.f_req   = 1'b0;
        tick();

        // ---------------- async reset mid-burst ----------------
        bus.mem_ready = 1'b0;
        bus.f_req     = 1'b1;
        bus.f_addr    = 16'h1000;
        tick();
        chk("ar_busy", 16'(bus.mem_req), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mem_req", 16'(bus.mem_req), 16'd0);
        chk("ar_state",   16'(bus.state), 16'(ARB_IDLE));
        chk("ar_f_done",  16'(bus.f_done), 16'd0);
        chk("ar_d_done",  16'(bus.d_done), 16'd0);
        chk("ar_hold",    16'(bus.hold), 16'd1);
        bus.f_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_idle_after", 16'(bus.state), 16'(ARB_IDLE));

`ifdef ARB_FAIRNESS_EN
        // ---------------- fetch anti-starvation ----------------
        begin
            int d_before;
            int d_after;
            int f_seen;
            d_before = 0;
            d_after  = 0;
            f_seen   = 0;
            bus.mem_ready = 1'b1;
            bus.d_req     = 1'b1;
            bus.d_we      = 1'b0;
            bus.d_addr    = 16'h2000;
            bus.f_req     = 1'b1;
            bus.f_addr    = 16'h1000;
            for (int cyc = 0; cyc < 60; cyc++) begin
                tick();
                if (bus.d_done) begin
                    if (f_seen != 0) d_after++;
                    else d_before++;
                end
                if (bus.f_done) begin
                    f_seen    = 1;
                    bus.f_req = 1'b0;
                end
                if (d_after >= 2) break;
            end
            bus.d_req = 1'b0;
            chk("fair_d_before", 16'(d_before), 16'd4);
            chk("fair_f_done",   16'(f_seen), 16'd1);
            chk("fair_d_resume", 16'(d_after), 16'd2);
            tick();
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
